// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and a width helper for the iteration counter.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/adder_n.sv
// Parametrised combinational adder: N-bit operands, N+1-bit sum with carry out.
module adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] OperandoA,
    input  logic [N-1:0] OperandoB,
    output logic [N:0]   Soma
);

    assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add multiplier, one partial product per clock.
// Signed mode multiplies magnitudes and negates the product when the signs differ.
module multiplicador_seq
    import multiplicador_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     OperandoA,
    input  logic [WIDTH-1:0]     OperandoB,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Produto
);

    localparam int CW = clog2(WIDTH);

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mq;
    logic [WIDTH-1:0]     acc;
    logic                 neg;
    logic [CW-1:0]        counter;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       soma;
    logic [2*WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg_in;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        addend  = mq[0] ? mcand : '0;
        shifted = {soma, mq[WIDTH-1:1]};
        mag_a   = OperandoA;
        mag_b   = OperandoB;
        neg_in  = 1'b0;
        if (SIGNED) begin
            // -2^(WIDTH-1) negates to itself, which read as unsigned is the right magnitude.
            if (OperandoA[WIDTH-1]) mag_a = -OperandoA;
            if (OperandoB[WIDTH-1]) mag_b = -OperandoB;
            neg_in = OperandoA[WIDTH-1] ^ OperandoB[WIDTH-1];
        end
    end

    adder_n #(
        .N (WIDTH)
    ) u_adder (
        .OperandoA (acc),
        .OperandoB (addend),
        .Soma      (soma)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Produto <= '0;
            counter <= '0;
            mcand   <= '0;
            mq      <= '0;
            acc     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        mcand   <= mag_a;
                        mq      <= mag_b;
                        acc     <= '0;
                        neg     <= neg_in;
                        counter <= CW'(WIDTH - 1);
                        Busy    <= 1'b1;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    {acc, mq} <= shifted;
                    counter   <= counter - 1'b1;
                    if (counter == '0) begin
                        Produto <= neg ? -shifted : shifted;
                        Done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
